// File: rtl/sort_n_floats_using_fsm_if.sv
// Request/result bus and comparator link of sort_n_floats_using_fsm.
// Element width FLEN comes from the shared `FLEN configuration define (64 when not set).
`ifndef FLEN
`define FLEN 64
`endif

interface sort_n_floats_using_fsm_if #(
   parameter int N = 4
);
   localparam int FLEN = `FLEN;

   logic                   valid_in;
   logic [0:N-1][FLEN-1:0] unsorted;
   logic                   valid_out;
   logic [0:N-1][FLEN-1:0] sorted;
   logic                   err;
   logic                   busy;
   logic [FLEN-1:0]        f_le_a;
   logic [FLEN-1:0]        f_le_b;
   logic                   f_le_res;
   logic                   f_le_err;

   // The requester also hosts the combinational f_less_or_equal unit.
   modport master (
      output valid_in, unsorted, f_le_res, f_le_err,
      input  valid_out, sorted, err, busy, f_le_a, f_le_b
   );

   modport slave (
      input  valid_in, unsorted, f_le_res, f_le_err,
      output valid_out, sorted, err, busy, f_le_a, f_le_b
   );
endinterface

// File: rtl/sort_n_floats_using_fsm.sv
// Bubble-sorts N FLEN-bit floats, one comparison per cycle through an external f_le unit.
// Define SORT_FLOATS_EARLY_EXIT_EN to finish after the first pass without swaps. FLEN from `FLEN.
`ifndef FLEN
`define FLEN 64
`endif

module sort_n_floats_using_fsm #(
   parameter int N = 4
) (
   input logic                      clk,
   input logic                      rst,
   sort_n_floats_using_fsm_if.slave bus
);
   localparam int FLEN = `FLEN;
   localparam int IW   = $clog2(N);
   localparam logic [IW-1:0] ZERO     = IW'(0);
   localparam logic [IW-1:0] ONE      = IW'(1);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t                 state_r;
   logic [0:N-1][FLEN-1:0] data_r;
   logic [0:N-1][FLEN-1:0] data_swap_s;
   logic [IW-1:0]          idx_r;
   logic [IW-1:0]          pass_r;
   logic [IW-1:0]          idx_plus_s;
   logic [IW-1:0]          idx_next_s;
   logic [IW-1:0]          idx_next_plus_s;
   logic [IW-1:0]          pass_next_s;
   logic                   last_in_pass_s;
   logic                   last_pass_s;
   logic                   do_swap_s;
   logic                   finish_s;
   logic                   valid_out_r;
   logic                   err_r;
   logic                   busy_r;
   logic [FLEN-1:0]        f_le_a_r;
   logic [FLEN-1:0]        f_le_b_r;

   assign idx_plus_s      = idx_r + ONE;
   assign last_in_pass_s  = (idx_r == (LAST_IDX - pass_r));
   assign last_pass_s     = (pass_r == LAST_IDX);
   assign idx_next_s      = last_in_pass_s ? ZERO : idx_plus_s;
   assign idx_next_plus_s = idx_next_s + ONE;
   assign pass_next_s     = last_in_pass_s ? (pass_r + ONE) : pass_r;
   // Equal operands report a<=b, so they never swap and the sort stays stable.
   assign do_swap_s       = (state_r == CMP) & ~bus.f_le_res & ~bus.f_le_err;

`ifdef SORT_FLOATS_EARLY_EXIT_EN
   logic swapped_r;
   logic pass_swapped_s;
   assign pass_swapped_s = swapped_r | do_swap_s;
   assign finish_s       = last_in_pass_s & (last_pass_s | ~pass_swapped_s);
`else
   assign finish_s       = last_in_pass_s & last_pass_s;
`endif

   // Buffer image after the current compare-and-swap.
   always_comb begin
      data_swap_s = data_r;
      if (do_swap_s) begin
         data_swap_s[idx_r]      = data_r[idx_plus_s];
         data_swap_s[idx_plus_s] = data_r[idx_r];
      end else begin
         data_swap_s = data_r;
      end
   end

   // Sort controller; comparator operands are preloaded so they are valid on entering each CMP cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         data_r      <= '0;
         idx_r       <= ZERO;
         pass_r      <= ZERO;
         valid_out_r <= 1'b0;
         err_r       <= 1'b0;
         busy_r      <= 1'b0;
         f_le_a_r    <= {FLEN{1'b0}};
         f_le_b_r    <= {FLEN{1'b0}};
`ifdef SORT_FLOATS_EARLY_EXIT_EN
         swapped_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.valid_in) begin
                  state_r  <= CMP;
                  data_r   <= bus.unsorted;
                  idx_r    <= ZERO;
                  pass_r   <= ZERO;
                  busy_r   <= 1'b1;
                  f_le_a_r <= bus.unsorted[0];
                  f_le_b_r <= bus.unsorted[1];
`ifdef SORT_FLOATS_EARLY_EXIT_EN
                  swapped_r <= 1'b0;
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            CMP: begin
               if (bus.f_le_err) begin
                  state_r     <= ERR;
                  valid_out_r <= 1'b1;
                  err_r       <= 1'b1;
                  f_le_a_r    <= {FLEN{1'b0}};
                  f_le_b_r    <= {FLEN{1'b0}};
               end else if (finish_s) begin
                  state_r     <= DONE;
                  data_r      <= data_swap_s;
                  valid_out_r <= 1'b1;
                  idx_r       <= ZERO;
                  pass_r      <= ZERO;
                  f_le_a_r    <= {FLEN{1'b0}};
                  f_le_b_r    <= {FLEN{1'b0}};
               end else begin
                  state_r  <= CMP;
                  data_r   <= data_swap_s;
                  idx_r    <= idx_next_s;
                  pass_r   <= pass_next_s;
                  f_le_a_r <= data_swap_s[idx_next_s];
                  f_le_b_r <= data_swap_s[idx_next_plus_s];
`ifdef SORT_FLOATS_EARLY_EXIT_EN
                  swapped_r <= last_in_pass_s ? 1'b0 : pass_swapped_s;
`endif
               end
            end
            DONE, ERR: begin
               state_r     <= IDLE;
               valid_out_r <= 1'b0;
               err_r       <= 1'b0;
               busy_r      <= 1'b0;
               idx_r       <= ZERO;
               pass_r      <= ZERO;
            end
            default: begin
               state_r     <= IDLE;
               valid_out_r <= 1'b0;
               err_r       <= 1'b0;
               busy_r      <= 1'b0;
               f_le_a_r    <= {FLEN{1'b0}};
               f_le_b_r    <= {FLEN{1'b0}};
            end
         endcase
      end
   end

   assign bus.sorted    = data_r;
   assign bus.valid_out = valid_out_r;
   assign bus.err       = err_r;
   assign bus.busy      = busy_r;
   assign bus.f_le_a    = f_le_a_r;
   assign bus.f_le_b    = f_le_b_r;
endmodule

// File: tb/tb_sort_n_floats_using_fsm.sv
// Bench for sort_n_floats_using_fsm (N=4, FP64): directed cases plus random vectors
// checked against a real-valued insertion-sort model; also hosts the f_le comparator.
`ifndef FLEN
`define FLEN 64
`endif

module tb_sort_n_floats_using_fsm;
   localparam int N   = 4;
   localparam int FL  = `FLEN;
   localparam int LAT = N * (N - 1) / 2 + 1;
   typedef logic [FL-1:0] word_t;

   localparam word_t P3   = 64'h4008000000000000;
   localparam word_t P2   = 64'h4000000000000000;
   localparam word_t P1   = 64'h3FF0000000000000;
   localparam word_t M1   = 64'hBFF0000000000000;
   localparam word_t Z0   = 64'h0000000000000000;
   localparam word_t QNAN = 64'h7FF8000000000000;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   sort_n_floats_using_fsm_if #(.N(N)) bus ();
   sort_n_floats_using_fsm #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic is_nan(input word_t w);
      return (w[62:52] == 11'h7FF) && (w[51:0] != 52'h0);
   endfunction

   // Combinational f_less_or_equal unit.
   always_comb begin
      bus.f_le_err = is_nan(bus.f_le_a) || is_nan(bus.f_le_b);
      bus.f_le_res = 1'b0;
      if (!bus.f_le_err) bus.f_le_res = ($bitstoreal(bus.f_le_a) <= $bitstoreal(bus.f_le_b));
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: ascending order of the real values (insertion sort on reals).
   function automatic void ref_sort(input word_t v[N], output word_t s[N]);
      real r[N];
      real t;
      int  j;
      for (int i = 0; i < N; i++) r[i] = $bitstoreal(v[i]);
      for (int i = 1; i < N; i++) begin
         t = r[i];
         j = i;
         while (j > 0) begin
            if (r[j-1] > t) begin
               r[j] = r[j-1];
               j--;
            end else break;
         end
         r[j] = t;
      end
      for (int i = 0; i < N; i++) s[i] = $realtobits(r[i]);
   endfunction

   // Issue one request from an idle DUT and check latency, busy, err and result; exp_lat<0 only bounds latency.
   task automatic run_sort(input string tag, input word_t v[N], input word_t e[N],
                           input int exp_lat, input logic exp_err);
      int cyc;
      bus.valid_in = 1'b1;
      for (int i = 0; i < N; i++) bus.unsorted[i] = v[i];
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      cyc = 1;
      while (bus.valid_out !== 1'b1 && cyc < 64) begin
         check({tag, "_busy"}, bus.busy, 1);
         @(posedge clk); #1;
         cyc++;
      end
      if (exp_lat >= 0) check({tag, "_latency"}, cyc, exp_lat);
      else check({tag, "_latency_bound"}, (cyc <= LAT), 1);
      check({tag, "_busy_last"}, bus.busy, 1);
      check({tag, "_err"}, bus.err, exp_err);
      check({tag, "_fle_a_idle"}, bus.f_le_a, 0);
      for (int i = 0; i < N; i++) check($sformatf("%s_sorted%0d", tag, i), bus.sorted[i], e[i]);
      @(posedge clk); #1;
      check({tag, "_vout_clear"}, bus.valid_out, 0);
      check({tag, "_busy_clear"}, bus.busy, 0);
   endtask

   initial begin
      word_t v[N];
      word_t e[N];
      word_t other[N];
      word_t seq_a[6];
      word_t seq_b[6];
      int    pulses;
      int    k;

      rst = 1'b1;
      bus.valid_in = 1'b0;
      bus.unsorted = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_valid_out", bus.valid_out, 0);
      check("rst_err", bus.err, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_fle_a", bus.f_le_a, 0);
      check("rst_fle_b", bus.f_le_b, 0);
      for (int i = 0; i < N; i++) check($sformatf("rst_sorted%0d", i), bus.sorted[i], 0);

      v = '{P3, P2, P1, M1};
      e = '{M1, P1, P2, P3};
      run_sort("reversed", v, e, LAT, 1'b0);

      v = '{M1, P1, P2, P3};
`ifdef SORT_FLOATS_EARLY_EXIT_EN
      run_sort("presorted", v, v, N, 1'b0);
`else
      run_sort("presorted", v, v, LAT, 1'b0);
`endif

      v = '{P1, QNAN, P2, P3};
      run_sort("nan_first", v, v, 2, 1'b1);

      v = '{P3, P1, QNAN, Z0};
      e = '{P1, P3, QNAN, Z0};
      run_sort("nan_partial", v, e, 3, 1'b1);

      // Duplicates: follow the exact comparator operand sequence.
      seq_a = '{P2, P2, P2, P1, P2, P1};
      seq_b = '{P1, P2, P1, P2, P1, P1};
      v = '{P2, P1, P2, P1};
      bus.valid_in = 1'b1;
      for (int i = 0; i < N; i++) bus.unsorted[i] = v[i];
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      for (int c = 0; c < 6; c++) begin
         check($sformatf("dup_fle_a%0d", c), bus.f_le_a, seq_a[c]);
         check($sformatf("dup_fle_b%0d", c), bus.f_le_b, seq_b[c]);
         @(posedge clk); #1;
      end
      check("dup_valid_out", bus.valid_out, 1);
      e = '{P1, P1, P2, P2};
      for (int i = 0; i < N; i++) check($sformatf("dup_sorted%0d", i), bus.sorted[i], e[i]);
      @(posedge clk); #1;

      // A second request while busy is dropped.
      v = '{P3, P2, P1, M1};
      e = '{M1, P1, P2, P3};
      other = '{Z0, Z0, Z0, Z0};
      bus.valid_in = 1'b1;
      for (int i = 0; i < N; i++) bus.unsorted[i] = v[i];
      @(posedge clk); #1;
      pulses = 0;
      for (int c = 1; c <= 12; c++) begin
         bus.valid_in = (c == 2);
         if (c == 2) for (int i = 0; i < N; i++) bus.unsorted[i] = other[i];
         check($sformatf("drop_busy%0d", c), bus.busy, (c <= LAT));
         if (bus.valid_out === 1'b1) begin
            pulses++;
            check("drop_latency", c, LAT);
            for (int i = 0; i < N; i++) check($sformatf("drop_sorted%0d", i), bus.sorted[i], e[i]);
         end
         @(posedge clk); #1;
      end
      check("drop_pulses", pulses, 1);

      // Reset during the third comparison aborts silently.
      bus.valid_in = 1'b1;
      for (int i = 0; i < N; i++) bus.unsorted[i] = v[i];
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_fle_a", bus.f_le_a, 0);
      check("abort_sorted0", bus.sorted[0], 0);
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         if (bus.valid_out === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      check("abort_no_pulse", pulses, 0);
      run_sort("after_abort", v, e, LAT, 1'b0);

      // Reset beats a simultaneous request.
      rst = 1'b1;
      bus.valid_in = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.valid_in = 1'b0;
      check("rst_wins_busy", bus.busy, 0);
      check("rst_wins_sorted3", bus.sorted[3], 0);

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < N; i++) begin
            k = int'($urandom_range(80)) - 40;
            v[i] = $realtobits(real'(k) / 4.0);
         end
         ref_sort(v, e);
`ifdef SORT_FLOATS_EARLY_EXIT_EN
         run_sort($sformatf("rand%0d", t), v, e, -1, 1'b0);
`else
         run_sort($sformatf("rand%0d", t), v, e, LAT, 1'b0);
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sort_n_floats_using_fsm.md
SORT_N_FLOATS_USING_FSM -- requirements
Module: sort_n_floats_using_fsm

Interface
REQ-001 SHALL have parameter N, default 4, number of floating-point elements sorted per request; legal range 2..16.
REQ-002 SHALL take FLEN from the shared configuration header, not as a module parameter.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid_in  input  1  request strobe; accepted only when busy=0.
REQ-006 unsorted  input  [0:N-1][FLEN-1:0]  operands; sampled only in the accept cycle.
REQ-007 valid_out  output  1  one-cycle completion pulse.
REQ-008 sorted  output  [0:N-1][FLEN-1:0]  result, ascending order, index 0 smallest.
REQ-009 err  output  1  qualified by valid_out; 1 means the comparator reported an error.
REQ-010 busy  output  1  high from the cycle after accept until the valid_out cycle, inclusive.
REQ-011 f_le_a, f_le_b  output  FLEN  operands to the external combinational f_less_or_equal unit.
REQ-012 f_le_res, f_le_err  input  1  same-cycle comparator result (a<=b) and error (NaN operand).

Function
REQ-013 SHALL own an internal N-entry register buffer; the accept cycle copies unsorted into it.
REQ-014 SHALL use exactly one comparison per cycle through the f_le port; no module instances.
REQ-015 FSM states: IDLE, CMP, DONE, ERR.
REQ-016 IDLE->CMP on valid_in; CMP->CMP while comparisons remain; CMP->DONE after the last comparison; CMP->ERR on f_le_err; DONE->IDLE and ERR->IDLE unconditionally.
REQ-017 Order is bubble sort: pass p=0..N-2 compares pairs (i,i+1) for i=0..N-2-p; index i and pass counter p are registers.
REQ-018 In CMP: f_le_a=buf[i] and f_le_b=buf[i+1]; if f_le_res=0 and f_le_err=0, swap the two entries at the clock edge.
REQ-019 Equal values (f_le_res=1) SHALL NOT swap, so the sort is stable.
REQ-020 f_le_a and f_le_b SHALL be 0 in all states other than CMP.
REQ-021 sorted SHALL always drive the buffer contents; valid_out=1 only in DONE and ERR; err=1 only in ERR.
REQ-022 Latency (macro off): accept cycle to valid_out = N(N-1)/2 + 1 cycles (N=4: 7).
REQ-023 On error, sorting SHALL abort immediately; sorted shows the partially sorted buffer at abort; no further swaps.
REQ-024 valid_in while busy=1 SHALL be ignored (dropped, not queued).
REQ-025 valid_in in the DONE or ERR cycle SHALL be ignored; a new request is accepted from the following IDLE cycle.

Reset
REQ-026 rst SHALL force IDLE, i=0, p=0, valid_out=0, err=0, busy=0, f_le_a=f_le_b=0, and clear the buffer to 0.
REQ-027 rst asserted mid-operation SHALL abort without any valid_out pulse; rst wins over valid_in in the same cycle.

Configuration
REQ-028 Macro SORT_FLOATS_EARLY_EXIT_EN: when defined, track a per-pass swap flag; a completed pass with zero swaps SHALL go CMP->DONE at once.
REQ-029 With SORT_FLOATS_EARLY_EXIT_EN, an already-sorted input has latency N (N=4: 4).
REQ-030 Without SORT_FLOATS_EARLY_EXIT_EN, latency SHALL be fixed per REQ-022 regardless of the data.

Verification (N=4, FP64)
REQ-031 Reversed input {3.0,2.0,1.0,-1.0} (4008..,4000..,3FF0..,BFF0..) -> valid_out 7 cycles after accept; sorted={-1.0,1.0,2.0,3.0}; err=0.
REQ-032 Sorted input {-1.0,1.0,2.0,3.0} -> identical output; valid_out after 7 cycles (macro off) or 4 cycles (macro on).
REQ-033 Input {1.0,NaN 7FF8000000000000,2.0,3.0} with the model asserting f_le_err -> valid_out=1 and err=1 in the cycle after the first comparison, then IDLE.
REQ-034 Input {2.0,1.0,2.0,1.0} -> {1.0,1.0,2.0,2.0}; equal pairs cause no swap (check the f_le sequence).
REQ-035 Second valid_in pulse 2 cycles after accept -> ignored; exactly one valid_out; busy high throughout.
REQ-036 rst asserted in the 3rd CMP cycle -> no valid_out; busy=0 next cycle; a fresh request afterwards sorts correctly.
